// File: rtl/adc_volt_display.sv
// adc_volt_display: synchronises/debounces an 8-bit ADC code, scales it to mV, converts it to BCD
// and scans it onto a 4-digit 7-segment display. Define ADC_AVG_EN for a 4-sample moving average.
module adc_volt_display #(
    parameter int SAMPLE_DIV = 500000,
    parameter int SCAN_DIV   = 50000,
    parameter int STABLE_CYC = 4,
    parameter int VREF_MV    = 3300
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [7:0]  adc_data,
    output logic [15:0] mv_bcd,
    output logic        busy,
    output logic [7:0]  seg,
    output logic [3:0]  dig
);

    localparam int SAMPLE_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STAB_W   = $clog2(STABLE_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_SCALE, S_CONV, S_LOAD} state_t;

    state_t              state, state_nxt;
    logic [7:0]          sync1, sync2;
    logic [STAB_W-1:0]   stab_cnt;
    logic                stable;
    logic [SAMPLE_W-1:0] sample_cnt;
    logic                tick, pending, start;
    logic [7:0]          scale_code;
    logic [19:0]         product;
    logic [31:0]         sr, sr_adj;
    logic [3:0]          bit_cnt;
    logic [SCAN_W-1:0]   scan_cnt;
    logic                scan_on;
    logic [1:0]          digit_idx;
    logic [3:0]          nibble;
    logic [6:0]          seg_pat;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stab_cnt <= '0;
        end else begin
            sync1 <= adc_data;
            sync2 <= sync1;
            if (sync1 != sync2)
                stab_cnt <= '0;
            else if (stab_cnt != STAB_W'(STABLE_CYC))
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    assign stable = (stab_cnt == STAB_W'(STABLE_CYC));
    assign tick   = (sample_cnt == SAMPLE_W'(SAMPLE_DIV - 1));
    assign start  = (state == S_IDLE) && pending && stable;

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            sample_cnt <= '0;
            pending    <= 1'b0;
        end else begin
            sample_cnt <= tick ? '0 : sample_cnt + 1'b1;
            if (start)
                pending <= 1'b0;
            else if (tick && !busy)
                pending <= 1'b1;
        end
    end

`ifdef ADC_AVG_EN
    logic [7:0] win [4];
    logic       filled;
    logic [9:0] win_sum;

    // NOTE: the window is a handful of flops that must read as empty after reset, so it is reset explicitly.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) win[i] <= '0;
            filled <= 1'b0;
        end else if (start) begin
            if (!filled) begin
                for (int i = 0; i < 4; i++) win[i] <= sync2;
                filled <= 1'b1;
            end else begin
                win[3] <= win[2];
                win[2] <= win[1];
                win[1] <= win[0];
                win[0] <= sync2;
            end
        end
    end

    assign win_sum    = 10'(win[0]) + 10'(win[1]) + 10'(win[2]) + 10'(win[3]);
    assign scale_code = 8'(win_sum >> 2);
`else
    logic [7:0] code_lat;

    always_ff @(posedge sysclk) begin
        if (!reset)
            code_lat <= '0;
        else if (start)
            code_lat <= sync2;
    end

    assign scale_code = code_lat;
`endif

    assign product = 20'(scale_code) * 20'(VREF_MV);

    function automatic logic [15:0] add3(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int i = 0; i < 4; i++)
            if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        return res;
    endfunction

    assign sr_adj = {add3(sr[31:16]), sr[15:0]};

    always_ff @(posedge sysclk) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SCALE;
            S_SCALE: state_nxt = S_CONV;
            S_CONV:  if (bit_cnt == 4'd15) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            sr      <= '0;
            bit_cnt <= '0;
            mv_bcd  <= '0;
        end else begin
            case (state)
                S_SCALE: begin
                    sr      <= {16'h0000, 16'(product >> 8)};
                    bit_cnt <= '0;
                end
                S_CONV: begin
                    sr      <= {sr_adj[30:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                S_LOAD:  mv_bcd <= sr[31:16];
                default: ;
            endcase
        end
    end

    // Display scan: digit 0 is only enabled by the first scan step after reset.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            scan_cnt  <= '0;
            scan_on   <= 1'b0;
            digit_idx <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (!scan_on)
                scan_on <= 1'b1;
            else
                digit_idx <= digit_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign nibble = mv_bcd[{digit_idx, 2'b00} +: 4];

    always_comb begin
        case (nibble)
            4'd0:    seg_pat = 7'h3F;
            4'd1:    seg_pat = 7'h06;
            4'd2:    seg_pat = 7'h5B;
            4'd3:    seg_pat = 7'h4F;
            4'd4:    seg_pat = 7'h66;
            4'd5:    seg_pat = 7'h6D;
            4'd6:    seg_pat = 7'h7D;
            4'd7:    seg_pat = 7'h07;
            4'd8:    seg_pat = 7'h7F;
            4'd9:    seg_pat = 7'h6F;
            default: seg_pat = 7'h00;
        endcase
    end

    always_comb begin
        seg = 8'hFF;
        dig = 4'hF;
        if (scan_on) begin
            dig = ~(4'b0001 << digit_idx);
            if (nibble <= 4'd9)
                seg = ~{digit_idx == 2'd3, seg_pat};
        end
    end

endmodule

// File: tb/tb_adc_volt_display.sv
// Directed self-checking bench for adc_volt_display (SAMPLE_DIV=64, SCAN_DIV=8).
// Builds with ADC_AVG_EN defined run the averaging sequence instead of the raw-code sequence.
`timescale 1ns/1ps
module tb_adc_volt_display;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b0;
    logic [7:0]  adc_data;
    logic [15:0] mv_bcd;
    logic        busy;
    logic [7:0]  seg;
    logic [3:0]  dig;

    int vectors     = 0;
    int miscompares = 0;

    adc_volt_display #(
        .SAMPLE_DIV(64),
        .SCAN_DIV  (8),
        .STABLE_CYC(4),
        .VREF_MV   (3300)
    ) dut (
        .sysclk  (sysclk),
        .reset   (reset),
        .adc_data(adc_data),
        .mv_bcd  (mv_bcd),
        .busy    (busy),
        .seg     (seg),
        .dig     (dig)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"},  seg,    8'hFF);
        check({tag, "_dig"},  dig,    4'hF);
        check({tag, "_mv"},   mv_bcd, 16'h0000);
        check({tag, "_busy"}, busy,   1'b0);
    endtask

    task automatic measure_conv(input string tag, input logic [15:0] exp);
        int t = 0;
        int len = 0;
        while (!busy && t < 300) begin
            @(negedge sysclk);
            t++;
        end
        check({tag, "_start"}, busy, 1'b1);
        if (busy) begin
            while (busy && len < 40) begin
                len++;
                @(negedge sysclk);
            end
            check({tag, "_busy_len"}, len, 18);
            check({tag, "_mv"}, mv_bcd, exp);
        end
    endtask

    task automatic set_code(input logic [7:0] code);
        int t = 0;
        adc_data = code;
        cyc(10);
        while (busy && t < 40) begin
            @(negedge sysclk);
            t++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_dig [4];
        logic [7:0] exp_seg [4];
        logic [3:0] prev;
        int t, hits, lat;
        exp_dig = '{4'hE, 4'hD, 4'hB, 4'h7};
        exp_seg = '{8'hC0, 8'h92, 8'h82, 8'h79};

`ifdef ADC_AVG_EN
        adc_data = 8'h40;
`else
        adc_data = 8'h80;
`endif
        // T1: reset and the quiet period before the first scan step
        reset = 1'b0;
        cyc(3);
        check_reset_outputs("t1_in_reset");
        reset = 1'b1;
        cyc(2);
        check_reset_outputs("t1_after_release");
        t = 0;
        while (dig == 4'hF && t < 20) begin
            @(negedge sysclk);
            t++;
        end
        check("t1_first_digit", dig, 4'hE);

`ifdef ADC_AVG_EN
        // T6: 4-entry average, first code pre-fills the window
        measure_conv("t6_40", 16'h0825);
        set_code(8'hC0);
        measure_conv("t6_c0_1", 16'h1237);
        measure_conv("t6_c0_2", 16'h1650);
        measure_conv("t6_c0_3", 16'h2062);
`else
        // T2: 0x80 -> 1.650 V
        measure_conv("t2_80", 16'h1650);

        // T5a: scan order and segment patterns for 1650
        t = 0;
        while (dig != 4'hE && t < 40) begin
            @(negedge sysclk);
            t++;
        end
        check("t5_dig0", dig, exp_dig[0]);
        check("t5_seg0", seg, exp_seg[0]);
        for (int k = 1; k < 4; k++) begin
            prev = dig;
            t = 0;
            while (dig == prev && t < 20) begin
                @(negedge sysclk);
                t++;
            end
            check($sformatf("t5_dig%0d", k), dig, exp_dig[k]);
            check($sformatf("t5_seg%0d", k), seg, exp_seg[k]);
        end

        // T3: boundary codes
        set_code(8'hFF);
        measure_conv("t3_ff", 16'h3287);
        set_code(8'h00);
        measure_conv("t3_00", 16'h0000);
        set_code(8'h01);
        measure_conv("t3_01", 16'h0012);

        // T4: unstable input blocks conversion across ticks
        hits = 0;
        for (int i = 0; i < 160; i++) begin
            if (i % 2 == 0) adc_data = (i % 4 == 0) ? 8'h10 : 8'h20;
            @(negedge sysclk);
            if (busy) hits++;
        end
        check("t4_no_conv", hits, 0);
        adc_data = 8'h33;
        lat = 0;
        while (!busy && lat < 30) begin
            @(negedge sysclk);
            lat++;
        end
        check("t4_start_latency_ok", (lat >= 6 && lat <= 7), 1'b1);
        measure_conv("t4_33", 16'h0657);
`endif

        // T5b: reset in the middle of a conversion
        t = 0;
        while (!busy && t < 300) begin
            @(negedge sysclk);
            t++;
        end
        check("t5_rst_conv_started", busy, 1'b1);
        cyc(5);
        reset = 1'b0;
        cyc(2);
        check_reset_outputs("t5_rst_during");
        reset = 1'b1;
        cyc(1);
        check_reset_outputs("t5_rst_after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
